// File: rtl/wash_sequencer.sv
// Washing-machine cycle sequencer: fill, wash, drain, rinse, spin, with pause,
// cancel and door-fault handling. ctrl mirrors the state code; other outputs registered.
module wash_sequencer #(
  parameter int PRESCALE = 16,
  parameter int FILL_T   = 8,
  parameter int DRAIN_T  = 4,
  parameter int RINSE_T  = 6,
  parameter int SPIN_T   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cancel,
  input  logic       pause,
  input  logic       door_closed,
  input  logic       water_full,
  input  logic [7:0] wash_time,
  output logic [2:0] ctrl,
  output logic [7:0] data_out,
  output logic       door_lock,
  output logic       busy,
  output logic       done,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WASH  = 3'd2,
    S_DRAIN = 3'd3,
    S_RINSE = 3'd4,
    S_SPIN  = 3'd5,
    S_FAULT = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  state_t     state, state_next;
  logic [7:0] psc, psc_next;
  logic [7:0] cnt, cnt_next;
  logic [7:0] wash_lat, wash_next;
  logic       abort, abort_next;
  logic       tick, expire, hold, advance;
  logic [7:0] data_out_d;
  logic       door_lock_d, busy_d, done_d, fault_d;

  function automatic logic [7:0] load_value(input state_t s, input logic [7:0] w);
    case (s)
      S_FILL:  return 8'(FILL_T);
      S_WASH:  return w;
      S_DRAIN: return 8'(DRAIN_T);
      S_RINSE: return 8'(RINSE_T);
      S_SPIN:  return 8'(SPIN_T);
      default: return 8'd0;
    endcase
  endfunction

  assign tick   = (psc == 8'(PRESCALE - 1));
  // A phase ends on the tick that takes the counter from 1 to 0; a zero load ends at once.
  assign expire = (cnt == 8'd0) || (tick && cnt == 8'd1);
  assign hold   = pause && (state inside {S_FILL, S_WASH, S_DRAIN, S_RINSE, S_SPIN});
  assign ctrl   = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      psc       <= 8'd0;
      cnt       <= 8'd0;
      wash_lat  <= 8'd0;
      abort     <= 1'b0;
      data_out  <= 8'd0;
      door_lock <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state     <= state_next;
      psc       <= psc_next;
      cnt       <= cnt_next;
      wash_lat  <= wash_next;
      abort     <= abort_next;
      data_out  <= data_out_d;
      door_lock <= door_lock_d;
      busy      <= busy_d;
      done      <= done_d;
      fault     <= fault_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    state_next = state;
    psc_next   = psc;
    cnt_next   = cnt;
    wash_next  = wash_lat;
    abort_next = abort;
    advance    = 1'b0;

    if (door_lock && !door_closed) begin
      state_next = S_FAULT;
    end else if (cancel && (state inside {S_FILL, S_WASH, S_RINSE, S_SPIN})) begin
      state_next = S_DRAIN;
      abort_next = 1'b1;
    end else if (!hold) begin
      case (state)
        S_IDLE: begin
          if (start && door_closed) begin
            state_next = S_FILL;
            wash_next  = wash_time;
            abort_next = 1'b0;
          end
        end
        S_FILL: begin
          if (water_full)  state_next = S_WASH;
          else if (expire) state_next = S_FAULT;
          else             advance    = 1'b1;
        end
        S_WASH: begin
          if (expire) state_next = S_DRAIN;
          else        advance    = 1'b1;
        end
        S_DRAIN: begin
          if (expire) state_next = abort ? S_IDLE : S_RINSE;
          else        advance    = 1'b1;
        end
        S_RINSE: begin
          if (expire) state_next = S_SPIN;
          else        advance    = 1'b1;
        end
        S_SPIN: begin
          if (expire) state_next = S_DONE;
          else        advance    = 1'b1;
        end
        S_DONE:  state_next = S_IDLE;
        S_FAULT: if (cancel) state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end

    if (state_next != state) begin
      psc_next = 8'd0;
      cnt_next = load_value(state_next, wash_next);
    end else if (advance) begin
      psc_next = tick ? 8'd0 : psc + 8'd1;
      cnt_next = tick ? cnt - 8'd1 : cnt;
    end
  end

  always_comb begin
    data_out_d  = (state_next inside {S_WASH, S_DRAIN, S_RINSE, S_SPIN}) ? cnt_next : 8'd0;
    door_lock_d = state_next inside {S_FILL, S_WASH, S_DRAIN, S_RINSE, S_SPIN};
    busy_d      = (state_next != S_IDLE);
    done_d      = (state_next == S_DONE);
    fault_d     = (state_next == S_FAULT);
  end

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed bench for wash_sequencer with PRESCALE=4, FILL_T=4, DRAIN_T=2,
// RINSE_T=3, SPIN_T=5; expected values are hand-computed from those settings.
module tb_wash_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cancel = 1'b0;
  logic       pause = 1'b0;
  logic       door_closed = 1'b1;
  logic       water_full = 1'b0;
  logic [7:0] wash_time = 8'd0;
  logic [2:0] ctrl;
  logic [7:0] data_out;
  logic       door_lock, busy, done, fault;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] seq_code;
  int          cyc [8];
  int          done_cnt;
  logic [7:0]  first_dout [8];

  wash_sequencer #(
    .PRESCALE(4),
    .FILL_T  (4),
    .DRAIN_T (2),
    .RINSE_T (3),
    .SPIN_T  (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cancel     (cancel),
    .pause      (pause),
    .door_closed(door_closed),
    .water_full (water_full),
    .wash_time  (wash_time),
    .ctrl       (ctrl),
    .data_out   (data_out),
    .door_lock  (door_lock),
    .busy       (busy),
    .done       (done),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until ctrl reaches stop_state, recording state sequence and per-state cycle counts.
  task automatic run_until(input logic [2:0] stop_state, input int budget);
    logic [2:0] last;
    bit hit;
    hit = 1'b0;
    for (int s = 0; s < 8; s++) begin
      cyc[s] = 0;
      first_dout[s] = 8'hxx;
    end
    seq_code = 32'(ctrl);
    cyc[ctrl] = 1;
    first_dout[ctrl] = data_out;
    done_cnt = done ? 1 : 0;
    last = ctrl;
    for (int i = 0; i < budget; i++) begin
      step();
      cyc[ctrl]++;
      if (done) done_cnt++;
      if (ctrl != last) begin
        seq_code = (seq_code << 4) | 32'(ctrl);
        first_dout[ctrl] = data_out;
        last = ctrl;
      end
      if (ctrl == stop_state) begin
        hit = 1'b1;
        break;
      end
    end
    n_chk++;
    if (!hit) begin
      n_fail++;
      $display("FAIL run_until: state=%0d after %0d cycles, required to reach %0d", ctrl, budget, stop_state);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    n_chk++;
    if ({ctrl, data_out, door_lock, busy, done, fault} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: ctrl=%0d data_out=%0d lock=%b busy=%b done=%b fault=%b, required all 0",
               ctrl, data_out, door_lock, busy, done, fault);
    end
    start = 1'b1;
    step();
    step();
    n_chk++;
    if (ctrl !== 3'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_holds: ctrl=%0d busy=%b, required 0/0", ctrl, busy);
    end
    start = 1'b0;
    rst = 1'b1;
    step();
  endtask

  task automatic test_full_run();
    door_closed = 1'b1;
    water_full = 1'b0;
    wash_time = 8'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    n_chk++;
    if (ctrl !== 3'd1 || door_lock !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL full_fill_entry: ctrl=%0d lock=%b busy=%b, required 1/1/1", ctrl, door_lock, busy);
    end
    for (int i = 0; i < 9; i++) step();
    n_chk++;
    if (ctrl !== 3'd1) begin
      n_fail++;
      $display("FAIL full_fill_wait: ctrl=%0d, required 1", ctrl);
    end
    water_full = 1'b1;
    run_until(3'd0, 200);
    n_chk++;
    if (seq_code !== 32'h0123_4570) begin
      n_fail++;
      $display("FAIL full_sequence: got %h, required 01234570", seq_code);
    end
    n_chk++;
    if (cyc[2] != 12 || cyc[3] != 8 || cyc[4] != 12 || cyc[5] != 20) begin
      n_fail++;
      $display("FAIL full_durations: wash=%0d drain=%0d rinse=%0d spin=%0d, required 12/8/12/20",
               cyc[2], cyc[3], cyc[4], cyc[5]);
    end
    n_chk++;
    if (done_cnt != 1 || cyc[7] != 1) begin
      n_fail++;
      $display("FAIL full_done_pulse: done cycles=%0d done-state cycles=%0d, required 1/1", done_cnt, cyc[7]);
    end
    n_chk++;
    if (first_dout[2] !== 8'd3 || first_dout[5] !== 8'd5) begin
      n_fail++;
      $display("FAIL full_data_out: wash start=%0d spin start=%0d, required 3/5", first_dout[2], first_dout[5]);
    end
    n_chk++;
    if (busy !== 1'b0 || data_out !== 8'd0 || door_lock !== 1'b0) begin
      n_fail++;
      $display("FAIL full_idle_outputs: busy=%b data_out=%0d lock=%b, required 0/0/0", busy, data_out, door_lock);
    end
    water_full = 1'b0;
  endtask

  task automatic test_fill_timeout();
    water_full = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    run_until(3'd6, 100);
    n_chk++;
    if (cyc[1] != 16) begin
      n_fail++;
      $display("FAIL timeout_fill_cycles: got %0d, required 16", cyc[1]);
    end
    n_chk++;
    if (fault !== 1'b1 || door_lock !== 1'b0 || busy !== 1'b1 || data_out !== 8'd0) begin
      n_fail++;
      $display("FAIL timeout_fault_outputs: fault=%b lock=%b busy=%b data_out=%0d, required 1/0/1/0",
               fault, door_lock, busy, data_out);
    end
    step();
    step();
    n_chk++;
    if (ctrl !== 3'd6) begin
      n_fail++;
      $display("FAIL timeout_sticky: ctrl=%0d, required 6", ctrl);
    end
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    n_chk++;
    if (ctrl !== 3'd0 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_cancel: ctrl=%0d fault=%b, required 0/0", ctrl, fault);
    end
  endtask

  task automatic test_pause();
    int  wcount;
    logic frozen_ok;
    wcount = 0;
    frozen_ok = 1'b1;
    wash_time = 8'd3;
    water_full = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int i = 0; i < 100; i++) begin
      if (ctrl == 3'd2) begin
        wcount++;
        if (wcount >= 5 && wcount <= 25 && data_out !== 8'd2) frozen_ok = 1'b0;
      end else if (wcount > 0) begin
        break;
      end
      pause = (wcount >= 5 && wcount < 25);
      step();
    end
    pause = 1'b0;
    n_chk++;
    if (!frozen_ok) begin
      n_fail++;
      $display("FAIL pause_frozen: data_out moved during pause, required to stay 2");
    end
    n_chk++;
    if (wcount != 32) begin
      n_fail++;
      $display("FAIL pause_wash_length: got %0d, required 32", wcount);
    end
    run_until(3'd0, 200);
    n_chk++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL pause_completion: done cycles=%0d, required 1", done_cnt);
    end
    water_full = 1'b0;
  endtask

  task automatic test_cancel_spin();
    wash_time = 8'd2;
    water_full = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    run_until(3'd5, 200);
    step();
    step();
    step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    n_chk++;
    if (ctrl !== 3'd3) begin
      n_fail++;
      $display("FAIL cancel_to_drain: ctrl=%0d, required 3", ctrl);
    end
    run_until(3'd0, 100);
    n_chk++;
    if (cyc[3] != 8 || seq_code !== 32'h30) begin
      n_fail++;
      $display("FAIL cancel_drain: drain cycles=%0d seq=%h, required 8/30", cyc[3], seq_code);
    end
    n_chk++;
    if (done_cnt != 0) begin
      n_fail++;
      $display("FAIL cancel_no_done: done cycles=%0d, required 0", done_cnt);
    end
    water_full = 1'b0;
  endtask

  task automatic test_door_cancel_rinse();
    wash_time = 8'd1;
    water_full = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    run_until(3'd4, 200);
    step();
    door_closed = 1'b0;
    cancel = 1'b1;
    step();
    n_chk++;
    if (ctrl !== 3'd6 || fault !== 1'b1 || door_lock !== 1'b0) begin
      n_fail++;
      $display("FAIL door_priority: ctrl=%0d fault=%b lock=%b, required 6/1/0", ctrl, fault, door_lock);
    end
    step();
    n_chk++;
    if (ctrl !== 3'd0) begin
      n_fail++;
      $display("FAIL door_fault_cancel: ctrl=%0d, required 0", ctrl);
    end
    cancel = 1'b0;
    door_closed = 1'b1;
    water_full = 1'b0;
  endtask

  task automatic test_boundary();
    door_closed = 1'b0;
    start = 1'b1;
    step();
    step();
    n_chk++;
    if (ctrl !== 3'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL open_door_start: ctrl=%0d busy=%b, required 0/0", ctrl, busy);
    end
    door_closed = 1'b1;
    wash_time = 8'd0;
    water_full = 1'b1;
    step();
    run_until(3'd0, 200);
    start = 1'b0;
    n_chk++;
    if (cyc[2] != 1 || seq_code !== 32'h0123_4570) begin
      n_fail++;
      $display("FAIL zero_wash: wash cycles=%0d seq=%h, required 1/01234570", cyc[2], seq_code);
    end
    n_chk++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL start_while_busy: done cycles=%0d, required 1", done_cnt);
    end
    water_full = 1'b0;
  endtask

  task automatic test_reset_midcycle();
    wash_time = 8'd5;
    water_full = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    #3;
    rst = 1'b0;
    #1;
    n_chk++;
    if (ctrl !== 3'd0 || busy !== 1'b0 || door_lock !== 1'b0 || data_out !== 8'd0) begin
      n_fail++;
      $display("FAIL async_reset: ctrl=%0d busy=%b lock=%b data_out=%0d, required 0/0/0/0",
               ctrl, busy, door_lock, data_out);
    end
    step();
    rst = 1'b1;
    step();
    step();
    n_chk++;
    if (ctrl !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_needs_start: ctrl=%0d, required 0", ctrl);
    end
    water_full = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_fill_timeout();
    test_pause();
    test_cancel_spin();
    test_door_cancel_rinse();
    test_boundary();
    test_reset_midcycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
